// File: rtl/sha256_func_sigma0.sv
// sha256_func_sigma0: registered SHA-256 big sigma0 of A; FUNC_SIGMA0_SMALL_EN adds small sigma0 selected by mode.
module sha256_func_sigma0 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mode,
  input  logic [31:0] in_A,
  output logic [31:0] func,
  output logic        out_valid
);
  logic [31:0] func_q, func_d, big_s0, func_next;
  logic        out_valid_q, out_valid_d;
  assign big_s0 = {in_A[1:0], in_A[31:2]} ^ {in_A[12:0], in_A[31:13]} ^ {in_A[21:0], in_A[31:22]};
`ifdef FUNC_SIGMA0_SMALL_EN
  logic [31:0] small_s0;
  assign small_s0 = {in_A[6:0], in_A[31:7]} ^ {in_A[17:0], in_A[31:18]} ^ {3'b000, in_A[31:3]};
  assign func_next = mode ? small_s0 : big_s0;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign func_next = big_s0;
`endif
  always_comb begin
    func_d      = in_valid ? func_next : func_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      func_q      <= 32'h0;
      out_valid_q <= 1'b0;
    end else begin
      func_q      <= func_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign func      = func_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_sha256_func_sigma0.sv
// tb_sha256_func_sigma0: directed-vector bench for sha256_func_sigma0 (expectations follow FUNC_SIGMA0_SMALL_EN).
module tb_sha256_func_sigma0;
  logic        clk = 1'b0;
  logic        rst, in_valid, mode;
  logic [31:0] in_A, func;
  logic        out_valid;
  int          passed = 0, total = 0;

  sha256_func_sigma0 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
    .in_A(in_A), .func(func), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic v, input logic m, input logic [31:0] a);
    rst = r; in_valid = v; mode = m; in_A = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] ef, input logic ev);
    total++;
    assert (func === ef && out_valid === ev) passed++;
    else $error("FAIL %s: func=%h out_valid=%b, expected func=%h out_valid=%b", tag, func, out_valid, ef, ev);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h6a09e667);
      check("reset", 32'h0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h6a09e667);
    check("S0_known", 32'hce20b47e, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h12345678);
    check("idle_hold", 32'hce20b47e, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hdeadbeef);
    check("idle_hold2", 32'hce20b47e, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h00000001);
    check("S0_one", 32'h40080400, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'hffffffff);
    check("S0_ones", 32'hffffffff, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h00000000);
    check("S0_zero", 32'h00000000, 1'b1);
`ifdef FUNC_SIGMA0_SMALL_EN
    drive(1'b0, 1'b1, 1'b1, 32'h00000001);
    check("s0_one", 32'h02004000, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'hffffffff);
    check("s0_ones", 32'h1fffffff, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'h6a09e667);
    check("s0_known", 32'hba0cf582, 1'b1);
`else
    drive(1'b0, 1'b1, 1'b1, 32'h00000001);
    check("mode_ignored_one", 32'h40080400, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'hffffffff);
    check("mode_ignored_ones", 32'hffffffff, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'h6a09e667);
    check("mode_ignored_known", 32'hce20b47e, 1'b1);
`endif
    drive(1'b0, 1'b1, 1'b0, 32'h00000001);
    check("stream_1", 32'h40080400, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'hffffffff);
    check("stream_2", 32'hffffffff, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h6a09e667);
    check("stream_rst", 32'h00000000, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h6a09e667);
    check("stream_dropped", 32'h00000000, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h6a09e667);
    check("after_rst", 32'hce20b47e, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
